ctrl_pipe: RTL and testbench

- Consumer end of the decode control bundles. Takes the EX/M/WB bundles and register fields from decode and carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and stalls on them by inserting a NOP bubble.
- Resolves BEQ in MEM and flushes the younger stages.
- Keeps saturating stall and flush counters for debug.

---
 rtl/ctrl_pkg.sv | 56 +++++
 rtl/ctrl_pipe_hazard.sv | 30 +++
 rtl/ctrl_pipe.sv | 99 +++++++++
 tb/tb_ctrl_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared widths, bundle bit positions and pipeline register layouts
// used by the control pipeline.
package ctrl_pkg;

  localparam int EX_W  = 4;
  localparam int M_W   = 3;
  localparam int WB_W  = 2;
  localparam int REG_W = 5;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_NOP   = 6'h00;

  localparam logic [EX_W-1:0] EX_NOP = '0;
  localparam logic [M_W-1:0]  M_NOP  = '0;
  localparam logic [WB_W-1:0] WB_NOP = '0;

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [M_W-1:0]   m;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic [M_W-1:0]   m;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] dst;
    logic             zero;
  } exmem_t;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] dst;
  } memwb_t;

  function automatic logic [REG_W-1:0] sel_dst(input logic regdst,
                                               input logic [REG_W-1:0] rt,
                                               input logic [REG_W-1:0] rd);
    return regdst ? rd : rt;
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard.sv
// Load-use stall and MEM-stage branch resolution; a taken branch overrides
// any stall raised in the same cycle.
module hazard_detect
  import ctrl_pkg::*;
(
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             exmem_branch_i,
  input  logic             exmem_zero_i,
  output logic             stall_o,
  output logic             take_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             pcsrc_o
);

  always_comb begin
    stall_o       = idex_memread_i && (idex_rt_i != '0) &&
                    ((idex_rt_i == id_rs_i) || (idex_rt_i == id_rt_i));
    take_o        = exmem_branch_i && exmem_zero_i;
    pc_write_o    = !stall_o || take_o;
    if_id_write_o = !stall_o || take_o;
    if_id_flush_o = take_o;
    pcsrc_o       = take_o;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use bubbling,
// branch squash and saturating debug counters.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [EX_W-1:0]  id_ex,
  input  logic [M_W-1:0]   id_m,
  input  logic [WB_W-1:0]  id_wb,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_alu_zero,
  output logic [EX_W-1:0]  ex_ctrl,
  output logic [REG_W-1:0] ex_rt,
  output logic [M_W-1:0]   mem_m,
  output logic [WB_W-1:0]  mem_wb,
  output logic [REG_W-1:0] mem_dst,
  output logic [WB_W-1:0]  wb_wb,
  output logic [REG_W-1:0] wb_dst,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             pcsrc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  idex_t            idex_q, idex_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall, take;

  hazard_detect u_hazard (
    .idex_memread_i (idex_q.m[M_MEMREAD]),
    .idex_rt_i      (idex_q.rt),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .exmem_branch_i (exmem_q.m[M_BRANCH]),
    .exmem_zero_i   (exmem_q.zero),
    .stall_o        (stall),
    .take_o         (take),
    .pc_write_o     (pc_write),
    .if_id_write_o  (if_id_write),
    .if_id_flush_o  (if_id_flush),
    .pcsrc_o        (pcsrc)
  );

  // rs is only needed by the hazard compare in ID, so ID/EX does not keep it.
  always_comb begin
    idex_d = '{ex: id_ex, m: id_m, wb: id_wb, rt: id_rt, rd: id_rd};
    if (stall || take) idex_d = '0;

    exmem_d = '{m: idex_q.m, wb: idex_q.wb,
                dst: sel_dst(idex_q.ex[EX_REGDST], idex_q.rt, idex_q.rd),
                zero: ex_alu_zero};
    if (take) exmem_d = '0;

    memwb_d = '{wb: exmem_q.wb, dst: exmem_q.dst};

    stall_cnt_d = stall_cnt_q;
    if (stall && !take && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_cnt_d = flush_cnt_q;
    if (take && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_ctrl   = idex_q.ex;
  assign ex_rt     = idex_q.rt;
  assign mem_m     = exmem_q.m;
  assign mem_wb    = exmem_q.wb;
  assign mem_dst   = exmem_q.dst;
  assign wb_wb     = memwb_q.wb;
  assign wb_dst    = memwb_q.dst;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scenario bench for ctrl_pipe: a writeback scoreboard plus inline checks
// on hazard, branch and counter behaviour.
module tb_ctrl_pipe;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       id_ex;
  logic [2:0]       id_m;
  logic [1:0]       id_wb;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic             ex_alu_zero;
  logic [3:0]       ex_ctrl;
  logic [4:0]       ex_rt;
  logic [2:0]       mem_m;
  logic [1:0]       mem_wb;
  logic [4:0]       mem_dst;
  logic [1:0]       wb_wb;
  logic [4:0]       wb_dst;
  logic             pc_write, if_id_write, if_id_flush, pcsrc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;
  logic [6:0] sb[$];

  always #5 clk = ~clk;

  ctrl_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_alu_zero(ex_alu_zero),
    .ex_ctrl(ex_ctrl), .ex_rt(ex_rt),
    .mem_m(mem_m), .mem_wb(mem_wb), .mem_dst(mem_dst),
    .wb_wb(wb_wb), .wb_dst(wb_dst),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .pcsrc(pcsrc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic drive(input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_ex = ex; id_m = m; id_wb = wb; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic drive_nop();
    drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  // exp is {wb, dst} of whatever enters ID/EX at this edge; squash turns the
  // instruction already in ID/EX into a bubble (taken branch in MEM).
  task automatic step(input logic [6:0] exp, input bit squash);
    logic [6:0] got;
    if (squash) sb[sb.size()-1] = 7'd0;
    sb.push_back(exp);
    @(posedge clk); #1;
    got = sb.pop_front();
    total++;
    if ({wb_wb, wb_dst} !== got) begin
      bad++;
      $display("FAIL wb_scoreboard got=%b expected=%b t=%0t", {wb_wb, wb_dst}, got, $time);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_alu_zero = 1'b0;
    drive(4'b1100, 3'b010, 2'b11, 5'd5, 5'd5, 5'd5);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_nop();
    sb.delete();
    sb.push_back(7'd0);
    sb.push_back(7'd0);
  endtask

  task automatic drain();
    drive_nop();
    repeat (3) step(7'd0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    chk("rst_ex_ctrl", 16'(ex_ctrl), 16'h0);
    chk("rst_ex_rt", 16'(ex_rt), 16'h0);
    chk("rst_mem", 16'({mem_m, mem_wb, mem_dst}), 16'h0);
    chk("rst_wb", 16'({wb_wb, wb_dst}), 16'h0);
    chk("rst_cnts", 16'({stall_cnt, flush_cnt}), 16'h0);
    chk("rst_ctl", 16'({pc_write, if_id_write, if_id_flush, pcsrc}), 16'b1100);
  endtask

  task automatic test_straight();
    do_reset();
    drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd7, 5'd3);
    step({2'b10, 5'd3}, 1'b0);
    chk("str_ex_ctrl", 16'(ex_ctrl), 16'b1100);
    chk("str_ex_rt", 16'(ex_rt), 16'd7);
    drive_nop();
    step(7'd0, 1'b0);
    chk("str_mem", 16'({mem_m, mem_wb, mem_dst}), 16'({3'b000, 2'b10, 5'd3}));
    step(7'd0, 1'b0);
    chk("str_wb", 16'({wb_wb, wb_dst}), 16'({2'b10, 5'd3}));
    drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ex_t[4] = '{4'b1100, 4'b0011, 4'b0001, 4'b1100};
    logic [1:0] wb_t[4] = '{2'b10, 2'b10, 2'b00, 2'b10};
    logic [4:0] rt_t[4] = '{5'd4, 5'd9, 5'd12, 5'd1};
    logic [4:0] rd_t[4] = '{5'd20, 5'd21, 5'd22, 5'd23};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(ex_t[i], 3'b000, wb_t[i], 5'd30, rt_t[i], rd_t[i]);
      step({wb_t[i], ex_t[i][3] ? rd_t[i] : rt_t[i]}, 1'b0);
      chk("b2b_ex_ctrl", 16'(ex_ctrl), 16'(ex_t[i]));
    end
    drain();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(4'b0001, 3'b010, 2'b11, 5'd2, 5'd5, 5'd0);
    step({2'b11, 5'd5}, 1'b0);
    drive(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd8);
    #1;
    chk("lu_stall_ctl", 16'({pc_write, if_id_write, if_id_flush, pcsrc}), 16'b0000);
    step(7'd0, 1'b0);
    chk("lu_bubble", 16'(ex_ctrl), 16'h0);
    chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);
    chk("lu_released", 16'({pc_write, if_id_write}), 16'b11);
    step({2'b10, 5'd8}, 1'b0);
    chk("lu_reissue", 16'(ex_ctrl), 16'b1100);
    drive(4'b0001, 3'b010, 2'b11, 5'd2, 5'd5, 5'd0);
    step({2'b11, 5'd5}, 1'b0);
    drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd5, 5'd9);
    #1;
    chk("lu_rt_match", 16'({pc_write, if_id_write}), 16'b00);
    step(7'd0, 1'b0);
    chk("lu_stall_cnt2", 16'(stall_cnt), 16'd2);
    step({2'b10, 5'd9}, 1'b0);
    drive(4'b0001, 3'b010, 2'b11, 5'd2, 5'd0, 5'd0);
    step({2'b11, 5'd0}, 1'b0);
    drive(4'b1100, 3'b000, 2'b10, 5'd0, 5'd0, 5'd8);
    #1;
    chk("lu_rt0_nostall", 16'({pc_write, if_id_write}), 16'b11);
    step({2'b10, 5'd8}, 1'b0);
    chk("lu_rt0_ex", 16'(ex_ctrl), 16'b1100);
    chk("lu_rt0_cnt", 16'(stall_cnt), 16'd2);
    drain();
  endtask

  task automatic test_branch();
    do_reset();
    drive(4'b0010, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0);
    step({2'b00, 5'd2}, 1'b0);
    ex_alu_zero = 1'b1;
    drive(4'b1100, 3'b000, 2'b10, 5'd3, 5'd4, 5'd10);
    step({2'b10, 5'd10}, 1'b0);
    ex_alu_zero = 1'b0;
    drive(4'b1100, 3'b000, 2'b10, 5'd3, 5'd4, 5'd11);
    #1;
    chk("br_take_ctl", 16'({pc_write, if_id_flush, pcsrc}), 16'b111);
    step(7'd0, 1'b1);
    chk("br_squash", 16'({ex_ctrl, mem_m}), 16'h0);
    chk("br_flush_cnt", 16'(flush_cnt), 16'd1);
    chk("br_after", 16'({if_id_flush, pcsrc}), 16'b00);
    drain();
    drive(4'b0010, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0);
    step({2'b00, 5'd2}, 1'b0);
    drive(4'b1100, 3'b000, 2'b10, 5'd3, 5'd4, 5'd12);
    step({2'b10, 5'd12}, 1'b0);
    drive(4'b1100, 3'b000, 2'b10, 5'd3, 5'd4, 5'd13);
    #1;
    chk("br_nt_ctl", 16'({if_id_flush, pcsrc}), 16'b00);
    step({2'b10, 5'd13}, 1'b0);
    chk("br_nt_ex", 16'(ex_ctrl), 16'b1100);
    chk("br_nt_cnt", 16'(flush_cnt), 16'd1);
    drain();
  endtask

  task automatic test_collision();
    do_reset();
    drive(4'b0010, 3'b100, 2'b00, 5'd1, 5'd2, 5'd0);
    step({2'b00, 5'd2}, 1'b0);
    ex_alu_zero = 1'b1;
    drive(4'b0001, 3'b010, 2'b11, 5'd2, 5'd5, 5'd0);
    step({2'b11, 5'd5}, 1'b0);
    ex_alu_zero = 1'b0;
    drive(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd8);
    #1;
    chk("col_ctl", 16'({pc_write, if_id_write, if_id_flush, pcsrc}), 16'b1111);
    step(7'd0, 1'b1);
    chk("col_stall_cnt", 16'(stall_cnt), 16'd0);
    chk("col_flush_cnt", 16'(flush_cnt), 16'd1);
    chk("col_ex", 16'(ex_ctrl), 16'h0);
    drain();
  endtask

  task automatic test_saturation();
    do_reset();
    #1;
    chk("sat_init", 16'(stall_cnt), 16'd0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 3'b010, 2'b11, 5'd2, 5'd5, 5'd0);
      step({2'b11, 5'd5}, 1'b0);
      drive(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd8);
      step(7'd0, 1'b0);
      chk("sat_cnt", 16'(stall_cnt), (i < 3) ? 16'(i + 1) : 16'd3);
      step({2'b10, 5'd8}, 1'b0);
      drive_nop();
      step(7'd0, 1'b0);
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    ex_alu_zero = 1'b0;
    drive_nop();
    test_reset();
    test_straight();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_collision();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
